// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared sizes, state encoding and defaults for the convolution
//               operand loader.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int DATA_W         = 8;
    localparam int IMG_N          = 4;
    localparam int FLT_N          = 3;
    localparam int IMG_BYTES      = IMG_N * IMG_N;
    localparam int FLT_BYTES      = FLT_N * FLT_N;
    localparam int RUN_CYCLES_DEF = 50;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD_IMG = 2'd1,
        ST_LOAD_FLT = 2'd2,
        ST_RUN      = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/conv_operand_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_operand_loader_if
// Description : Serial operand byte stream (valid/ready) feeding the loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_operand_loader_if #(
    parameter int DATA_W = conv_pkg::DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              keep_filter;

    modport master (
        output in_valid,
        output in_data,
        output keep_filter,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  keep_filter,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/byte_shift_bank.sv
`default_nettype none
// ============================================================================
// Module      : byte_shift_bank
// Description : N x DATA_W register bank with indexed write and async clear;
//               slot 0 is presented at the MSBs of the flat bus.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_shift_bank #(
    parameter int N      = 9,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                we,
    input  wire logic [IDX_W-1:0]    widx,
    input  wire logic [DATA_W-1:0]   wdata,
    output logic      [N*DATA_W-1:0] flat
);

    logic [DATA_W-1:0] r_slot [N];

    for (genvar i = 0; i < N; i++) begin : g_slot
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_slot[i] <= '0;
            end else if (we && (widx == IDX_W'(i))) begin
                r_slot[i] <= wdata;
            end
        end

        assign flat[(N-1-i)*DATA_W +: DATA_W] = r_slot[i];
    end

endmodule
`default_nettype wire

// File: rtl/conv_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : conv_operand_loader
// Description : Loads an image tile and filter from a byte stream, holds them
//               stable, and sequences the systolic array reset for one run.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_operand_loader #(
    parameter int DATA_W     = conv_pkg::DATA_W,
    parameter int IMG_N      = conv_pkg::IMG_N,
    parameter int FLT_N      = conv_pkg::FLT_N,
    parameter int RUN_CYCLES = conv_pkg::RUN_CYCLES_DEF
) (
    input  wire logic                            clk,
    input  wire logic                            rst,
    conv_operand_loader_if.slave                 stream,
    output logic [IMG_N*IMG_N*DATA_W-1:0]        img_flat,
    output logic [FLT_N*FLT_N*DATA_W-1:0]        flt_flat,
    output logic                                 array_rst,
    output logic                                 busy,
    output logic                                 done
);
    import conv_pkg::*;

    localparam int c_img_bytes = IMG_N * IMG_N;
    localparam int c_flt_bytes = FLT_N * FLT_N;
    localparam int c_idx_w     = $clog2((c_img_bytes > c_flt_bytes) ? c_img_bytes : c_flt_bytes);

    localparam logic [c_idx_w-1:0] c_img_last = c_idx_w'(c_img_bytes - 1);
    localparam logic [c_idx_w-1:0] c_flt_last = c_idx_w'(c_flt_bytes - 1);
    localparam logic [7:0]         c_run_last = 8'(RUN_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_idx_w-1:0] r_idx;
    logic [7:0]         r_run_cnt;
    logic               r_flt_loaded;

    logic               w_in_ready;
    logic               w_img_we;
    logic               w_flt_we;
    logic               w_idx_last;
    logic               w_run_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_img_we    = 1'b0;
        w_flt_we    = 1'b0;
        w_idx_last  = 1'b0;
        w_run_last  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_LOAD_IMG;
            end
            ST_LOAD_IMG: begin
                w_in_ready = 1'b1;
                w_img_we   = stream.in_valid;
                w_idx_last = (r_idx == c_img_last);
                // Filter reuse is only honoured once a filter has actually been loaded
                if (w_img_we && w_idx_last) begin
                    w_state_nxt = (stream.keep_filter && r_flt_loaded) ? ST_RUN : ST_LOAD_FLT;
                end
            end
            ST_LOAD_FLT: begin
                w_in_ready = 1'b1;
                w_flt_we   = stream.in_valid;
                w_idx_last = (r_idx == c_flt_last);
                if (w_flt_we && w_idx_last) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_run_last = (r_run_cnt == c_run_last);
                if (w_run_last) begin
                    w_state_nxt = ST_LOAD_IMG;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx        <= '0;
            r_run_cnt    <= '0;
            r_flt_loaded <= 1'b0;
            array_rst    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            if (w_img_we || w_flt_we) begin
                r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
            end
            if (w_flt_we && w_idx_last) begin
                r_flt_loaded <= 1'b1;
            end
            if (r_state == ST_RUN) begin
                r_run_cnt <= w_run_last ? '0 : r_run_cnt + 1'b1;
            end
            // Registered from next state so the array leaves reset exactly with RUN
            done      <= w_run_last;
            array_rst <= (w_state_nxt != ST_RUN);
            busy      <= (w_state_nxt == ST_RUN);
        end
    end

    assign stream.in_ready = w_in_ready;

    byte_shift_bank #(
        .N      (c_img_bytes),
        .DATA_W (DATA_W),
        .IDX_W  (c_idx_w)
    ) u_img_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (w_img_we),
        .widx  (r_idx),
        .wdata (stream.in_data),
        .flat  (img_flat)
    );

    byte_shift_bank #(
        .N      (c_flt_bytes),
        .DATA_W (DATA_W),
        .IDX_W  (c_idx_w)
    ) u_flt_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (w_flt_we),
        .widx  (r_idx),
        .wdata (stream.in_data),
        .flat  (flt_flat)
    );

endmodule
`default_nettype wire
